// File: rtl/ex_muldiv_pkg.sv
// Shared constants, operation record and decode helpers for the EX-stage RV32M unit.
package ex_muldiv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [6:0] OP_OP         = 7'b0110011;
    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;
    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_CALC = 2'd1;
    localparam logic [1:0] MD_DONE = 2'd2;

    // Everything about the in-flight instruction that must survive pipeline bubbles.
    typedef struct packed {
        logic [2:0] f3;
        logic [4:0] wd;
        logic       wreg;
        logic       neg_a;   // rs1 was treated as signed and negative
        logic       neg_b;   // rs2 was treated as signed and negative
        logic       dz;      // divisor was zero
    } md_op_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic rs1_signed(input logic [2:0] f3);
        return (f3 == MULH_F3) || (f3 == MULHSU_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f3);
        return (f3 == MULH_F3) || (f3 == DIV_F3) || (f3 == REM_F3);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Bundle between the id_ex stage register / ctrl and the mul-div unit.
interface ex_muldiv_if #(parameter int XLEN = 32);

    logic [6:0]      ex_aluop;
    logic [2:0]      ex_alufunct3;
    logic [6:0]      ex_alufunct7;
    logic [XLEN-1:0] ex_reg1;
    logic [XLEN-1:0] ex_reg2;
    logic [4:0]      ex_wd;
    logic            ex_wreg;

    logic [XLEN-1:0] md_result;
    logic [4:0]      md_wd;
    logic            md_wreg;
    logic            md_valid;
    logic            stallreq;

    modport master (
        output ex_aluop, ex_alufunct3, ex_alufunct7, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        input  md_result, md_wd, md_wreg, md_valid, stallreq
    );

    modport slave (
        input  ex_aluop, ex_alufunct3, ex_alufunct7, ex_reg1, ex_reg2, ex_wd, ex_wreg,
        output md_result, md_wd, md_wreg, md_valid, stallreq
    );

endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M unit: shared shift-add multiply / restoring divide on one
// 2*XLEN accumulator, operating on magnitudes with a sign fix at the end.
//
//  state   | meaning
//  --------+---------------------------------------------------------------
//  MD_IDLE | waiting for a MUL*/DIV*/REM* instruction; start cycle stalls
//  MD_CALC | one iteration per cycle, cnt counts XLEN..1, pipeline stalled
//  MD_DONE | result presented for one cycle, md_valid/md_wreg pulse
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN          = XLEN_DEF,
    parameter bit ZERO_SHORTCUT = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    ex_muldiv_if.slave bus
);

    localparam int CW = $clog2(XLEN + 1);

    logic [1:0]        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [2*XLEN-1:0] acc, acc_nxt;
    logic [XLEN-1:0]   opd, opd_nxt;
    md_op_t            op, op_nxt;
    logic [XLEN-1:0]   res, res_nxt;

    logic              start;
    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              zero_in;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_step;

    // Final sign correction and word select, applied to the finished accumulator.
    function automatic logic [XLEN-1:0] post_fix(input logic [2*XLEN-1:0] a, input md_op_t o);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quot;
        logic [XLEN-1:0]   rem;
        logic [XLEN-1:0]   r;
        prod = (o.neg_a ^ o.neg_b) ? -a : a;
        // x/0 must give all ones regardless of the dividend sign
        quot = ((o.neg_a ^ o.neg_b) && !o.dz) ? -a[XLEN-1:0] : a[XLEN-1:0];
        rem  = o.neg_a ? -a[2*XLEN-1:XLEN] : a[2*XLEN-1:XLEN];
        case (o.f3)
            MUL_F3:                       r = prod[XLEN-1:0];
            MULH_F3, MULHSU_F3, MULHU_F3: r = prod[2*XLEN-1:XLEN];
            DIV_F3, DIVU_F3:              r = quot;
            default:                      r = rem;
        endcase
        return r;
    endfunction

    // Start decode and operand pre-processing from the live id_ex outputs.
    always_comb begin
        start    = rst && (state == MD_IDLE) &&
                   (bus.ex_aluop == OP_OP) && (bus.ex_alufunct7 == MULDIV_FUNCT7);
        neg_a_in = rs1_signed(bus.ex_alufunct3) && bus.ex_reg1[XLEN-1];
        neg_b_in = rs2_signed(bus.ex_alufunct3) && bus.ex_reg2[XLEN-1];
        mag_a    = neg_a_in ? -bus.ex_reg1 : bus.ex_reg1;
        mag_b    = neg_b_in ? -bus.ex_reg2 : bus.ex_reg2;
        zero_in  = is_div(bus.ex_alufunct3) ? (bus.ex_reg2 == '0)
                                            : ((bus.ex_reg1 == '0) || (bus.ex_reg2 == '0));
    end

    // One iteration of each algorithm; acc = {hi, lo}, opd = multiplicand or divisor.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opd};
        mul_step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opd};
        div_step = div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    // Next-state, datapath and result register update.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        opd_nxt   = opd;
        op_nxt    = op;
        res_nxt   = res;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    op_nxt.f3    = bus.ex_alufunct3;
                    op_nxt.wd    = bus.ex_wd;
                    op_nxt.wreg  = bus.ex_wreg;
                    op_nxt.neg_a = neg_a_in;
                    op_nxt.neg_b = neg_b_in;
                    op_nxt.dz    = (bus.ex_reg2 == '0);
                    opd_nxt      = mag_b;
                    acc_nxt      = {{XLEN{1'b0}}, mag_a};
                    cnt_nxt      = CW'(XLEN);
                    state_nxt    = MD_CALC;
                    if (ZERO_SHORTCUT && zero_in) begin
                        // preload what the full iteration would have produced
                        acc_nxt   = is_div(bus.ex_alufunct3) ? {mag_a, {XLEN{1'b1}}} : '0;
                        state_nxt = MD_DONE;
                    end
                end
            end
            MD_CALC: begin
                acc_nxt = is_div(op.f3) ? div_step : mul_step;
                cnt_nxt = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_nxt = MD_DONE;
                end
            end
            MD_DONE: begin
                state_nxt = MD_IDLE;
            end
            default: begin
                state_nxt = MD_IDLE;
            end
        endcase
        if (state_nxt == MD_DONE) begin
            res_nxt = post_fix(acc_nxt, op_nxt);
        end
    end

    // State, accumulator and latched-operation registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
            acc   <= '0;
            opd   <= '0;
            op    <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            opd   <= opd_nxt;
            op    <= op_nxt;
            res   <= res_nxt;
        end
    end

    // Outputs decoded from registered state only, except the start-cycle stall.
    always_comb begin
        bus.md_result = res;
        bus.md_wd     = op.wd;
        bus.md_valid  = (state == MD_DONE);
        bus.md_wreg   = (state == MD_DONE) && op.wreg;
        bus.stallreq  = start || (state == MD_CALC);
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table plus back-to-back and reset-abort sequences.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_muldiv_if bus ();

    ex_muldiv dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_nop();
        bus.ex_aluop     = 7'b0010011;
        bus.ex_alufunct3 = 3'($urandom_range(0, 7));
        bus.ex_alufunct7 = 7'd0;
        bus.ex_reg1      = $urandom;
        bus.ex_reg2      = $urandom;
        bus.ex_wd        = 5'($urandom_range(0, 31));
        bus.ex_wreg      = 1'b1;
    endtask

    // A muldiv-looking instruction with random fields; must not disturb an op in flight.
    task automatic drive_junk();
        bus.ex_aluop     = OP_OP;
        bus.ex_alufunct3 = 3'($urandom_range(0, 7));
        bus.ex_alufunct7 = MULDIV_FUNCT7;
        bus.ex_reg1      = $urandom;
        bus.ex_reg2      = $urandom;
        bus.ex_wd        = 5'($urandom_range(0, 31));
        bus.ex_wreg      = 1'b1;
    endtask

    task automatic drive_op(input vec_t v);
        bus.ex_aluop     = OP_OP;
        bus.ex_alufunct3 = v.f3;
        bus.ex_alufunct7 = MULDIV_FUNCT7;
        bus.ex_reg1      = v.a;
        bus.ex_reg2      = v.b;
        bus.ex_wd        = v.wd;
        bus.ex_wreg      = v.wreg;
    endtask

    // Called just after a falling edge; returns at the falling edge of the DONE cycle.
    task automatic start_and_wait(input vec_t v, input string tag);
        int  k;
        int  stalls;
        int  early;
        bit  seen;
        drive_op(v);
        #1;
        check({tag, "_stall_start"}, 32'(bus.stallreq), 32'd1);
        stalls = 1;
        early  = 0;
        seen   = 1'b0;
        for (k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.md_valid) begin
                seen = 1'b1;
                break;
            end
            if (bus.stallreq) stalls++;
            if (bus.md_wreg) early++;
            drive_junk();
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: md_valid not seen within 40 cycles, required after %0d", tag, v.lat);
            drive_nop();
        end else begin
            check({tag, "_latency"}, 32'(k), 32'(v.lat));
            check({tag, "_stall_cycles"}, 32'(stalls), 32'(v.lat));
            check({tag, "_early_wreg"}, 32'(early), 32'd0);
            check({tag, "_result"}, bus.md_result, v.exp);
            check({tag, "_wd"}, 32'(bus.md_wd), 32'(v.wd));
            check({tag, "_wreg"}, 32'(bus.md_wreg), 32'(v.wreg));
            check({tag, "_stall_done"}, 32'(bus.stallreq), 32'd0);
            drive_nop();
        end
    endtask

    task automatic check_pulse_end(input string tag);
        @(negedge clk);
        check({tag, "_valid_pulse"}, 32'(bus.md_valid), 32'd0);
        check({tag, "_wreg_pulse"}, 32'(bus.md_wreg), 32'd0);
        check({tag, "_idle_stall"}, 32'(bus.stallreq), 32'd0);
    endtask

    initial begin
        vec_t vb;
        int   pulses;
        int   stalls;

        vecs[0]  = '{f3: MUL_F3,    a: 32'd7,        b: 32'hFFFFFFFD, wd: 5'd1,  wreg: 1'b1, exp: 32'hFFFFFFEB, lat: 33};
        vecs[1]  = '{f3: MULHU_F3,  a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, wd: 5'd2,  wreg: 1'b1, exp: 32'hFFFFFFFE, lat: 33};
        vecs[2]  = '{f3: MULH_F3,   a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, wd: 5'd3,  wreg: 1'b1, exp: 32'h00000000, lat: 33};
        vecs[3]  = '{f3: MULHSU_F3, a: 32'hFFFFFFFF, b: 32'd2,        wd: 5'd4,  wreg: 1'b1, exp: 32'hFFFFFFFF, lat: 33};
        vecs[4]  = '{f3: DIV_F3,    a: 32'hFFFFFFF9, b: 32'd2,        wd: 5'd5,  wreg: 1'b1, exp: 32'hFFFFFFFD, lat: 33};
        vecs[5]  = '{f3: REM_F3,    a: 32'hFFFFFFF9, b: 32'd2,        wd: 5'd6,  wreg: 1'b1, exp: 32'hFFFFFFFF, lat: 33};
        vecs[6]  = '{f3: DIVU_F3,   a: 32'd100,      b: 32'd7,        wd: 5'd7,  wreg: 1'b0, exp: 32'd14,       lat: 33};
        vecs[7]  = '{f3: REMU_F3,   a: 32'd100,      b: 32'd7,        wd: 5'd8,  wreg: 1'b1, exp: 32'd2,        lat: 33};
        vecs[8]  = '{f3: DIV_F3,    a: 32'd5,        b: 32'd0,        wd: 5'd9,  wreg: 1'b1, exp: 32'hFFFFFFFF, lat: 1};
        vecs[9]  = '{f3: REMU_F3,   a: 32'd5,        b: 32'd0,        wd: 5'd10, wreg: 1'b1, exp: 32'd5,        lat: 1};
        vecs[10] = '{f3: DIV_F3,    a: 32'h80000000, b: 32'hFFFFFFFF, wd: 5'd11, wreg: 1'b1, exp: 32'h80000000, lat: 33};
        vecs[11] = '{f3: REM_F3,    a: 32'h80000000, b: 32'hFFFFFFFF, wd: 5'd12, wreg: 1'b1, exp: 32'h00000000, lat: 33};
        vecs[12] = '{f3: MUL_F3,    a: 32'd0,        b: 32'h12345,    wd: 5'd13, wreg: 1'b1, exp: 32'h00000000, lat: 1};
        vecs[13] = '{f3: REM_F3,    a: 32'hFFFFFFF9, b: 32'd0,        wd: 5'd14, wreg: 1'b1, exp: 32'hFFFFFFF9, lat: 1};
        vecs[14] = '{f3: DIV_F3,    a: 32'hFFFFFFF9, b: 32'd0,        wd: 5'd15, wreg: 1'b1, exp: 32'hFFFFFFFF, lat: 1};
        vecs[15] = '{f3: MULH_F3,   a: 32'h80000000, b: 32'h80000000, wd: 5'd16, wreg: 1'b1, exp: 32'h40000000, lat: 33};
        vecs[16] = '{f3: MULHU_F3,  a: 32'h12345678, b: 32'h00000100, wd: 5'd0,  wreg: 1'b1, exp: 32'h00000012, lat: 33};

        rst_n = 1'b0;
        drive_nop();
        repeat (3) @(negedge clk);
        check("reset_result", bus.md_result, 32'd0);
        check("reset_wd", 32'(bus.md_wd), 32'd0);
        check("reset_valid", 32'(bus.md_valid), 32'd0);
        check("reset_wreg", 32'(bus.md_wreg), 32'd0);
        check("reset_stall", 32'(bus.stallreq), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            start_and_wait(vecs[i], $sformatf("vec%0d", i));
            check_pulse_end($sformatf("vec%0d", i));
        end

        // Back-to-back: a start presented in the DONE cycle is held until IDLE.
        @(negedge clk);
        start_and_wait(vecs[0], "b2b_mul");
        vb = '{f3: DIVU_F3, a: 32'd100, b: 32'd7, wd: 5'd21, wreg: 1'b1, exp: 32'd14, lat: 33};
        drive_op(vb);
        #1;
        check("b2b_no_start_in_done", 32'(bus.stallreq), 32'd0);
        check("b2b_done_wd", 32'(bus.md_wd), 32'd1);
        @(negedge clk);
        start_and_wait(vb, "b2b_divu");
        check_pulse_end("b2b_divu");

        // Reset ten cycles into an operation: aborted, nothing written afterwards.
        @(negedge clk);
        vb = '{f3: DIVU_F3, a: 32'd1000, b: 32'd3, wd: 5'd25, wreg: 1'b1, exp: 32'd333, lat: 33};
        drive_op(vb);
        #1;
        check("abort_stall_start", 32'(bus.stallreq), 32'd1);
        repeat (10) begin
            @(negedge clk);
            drive_junk();
        end
        #1;
        check("abort_stall_mid", 32'(bus.stallreq), 32'd1);
        rst_n = 1'b0;
        drive_op(vecs[0]);
        #1;
        check("abort_result", bus.md_result, 32'd0);
        check("abort_wd", 32'(bus.md_wd), 32'd0);
        check("abort_valid", 32'(bus.md_valid), 32'd0);
        check("abort_wreg", 32'(bus.md_wreg), 32'd0);
        check("abort_stall_in_reset", 32'(bus.stallreq), 32'd0);
        repeat (2) @(negedge clk);
        drive_nop();
        rst_n = 1'b1;
        pulses = 0;
        stalls = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.md_wreg || bus.md_valid) pulses++;
            if (bus.stallreq) stalls++;
            drive_nop();
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);
        check("abort_no_stall", 32'(stalls), 32'd0);

        @(negedge clk);
        start_and_wait(vb, "post_reset");
        check_pulse_end("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
